// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle controller.
package mc_pkg;

    localparam int MC_STATE_W = 4;

    typedef enum logic [MC_STATE_W-1:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEMADR   = 4'd2,
        ST_MEMREAD  = 4'd3,
        ST_MEMWB    = 4'd4,
        ST_MEMWRITE = 4'd5,
        ST_EXECUTER = 4'd6,
        ST_EXECUTEI = 4'd7,
        ST_ALUWB    = 4'd8,
        ST_BRANCH   = 4'd9
    } state_e;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_MOV = 3'b100;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCB_WD   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_8   = 2'b00;
    localparam logic [1:0] IMM_12  = 2'b01;
    localparam logic [1:0] IMM_B24 = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_B   = 2'b10;

endpackage

// File: rtl/mc_aludec.sv
// Data-processing Funct decode: ALU operation, flag-write enables, legality.
module mc_aludec
    import mc_pkg::*;
(
    input  logic [4:0] funct_i,
    output logic [2:0] alu_control_o,
    output logic [1:0] flag_w_o,
    output logic       valid_o
);
    // Unsupported commands fall back to ADD and are marked invalid so the
    // controller suppresses their register and flag writes.
    always_comb begin
        alu_control_o = ALU_ADD;
        valid_o       = 1'b1;
        unique case (funct_i[4:1])
            4'b0100: alu_control_o = ALU_ADD;
            4'b0010: alu_control_o = ALU_SUB;
            4'b0000: alu_control_o = ALU_AND;
            4'b1100: alu_control_o = ALU_ORR;
            4'b1101: alu_control_o = ALU_MOV;
            default: valid_o       = 1'b0;
        endcase
        flag_w_o[1] = funct_i[0] & valid_o;
        flag_w_o[0] = funct_i[0] & valid_o &
                      ((alu_control_o == ALU_ADD) | (alu_control_o == ALU_SUB));
    end
endmodule

// File: rtl/mc_condcheck.sv
// ARM condition-field evaluation against the {N,Z,C,V} flag register.
module mc_condcheck (
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       cond_ex_o
);
    logic n, z, c, v;
    assign {n, z, c, v} = flags_i;

    // Decode the 4-bit condition field; 1111 is treated as always.
    always_comb begin
        cond_ex_o = 1'b0;
        unique case (cond_i)
            4'b0000: cond_ex_o = z;
            4'b0001: cond_ex_o = ~z;
            4'b0010: cond_ex_o = c;
            4'b0011: cond_ex_o = ~c;
            4'b0100: cond_ex_o = n;
            4'b0101: cond_ex_o = ~n;
            4'b0110: cond_ex_o = v;
            4'b0111: cond_ex_o = ~v;
            4'b1000: cond_ex_o = c & ~z;
            4'b1001: cond_ex_o = ~(c & ~z);
            4'b1010: cond_ex_o = (n == v);
            4'b1011: cond_ex_o = (n != v);
            4'b1100: cond_ex_o = ~z & (n == v);
            4'b1101: cond_ex_o = z | (n != v);
            default: cond_ex_o = 1'b1;
        endcase
    end
endmodule

// File: rtl/mc_controller.sv
// Multi-cycle ARMv4-subset sequencer: Moore FSM, NZCV flags, condition gating.
// Optional build macro MEM_WAIT_EN adds mem_ready and stalls FETCH/MEMREAD/MEMWRITE.
//
// state    | meaning
// FETCH    | read IR at PC, PC <= PC+4
// DECODE   | register read, capture condition result
// MEMADR   | ALUOut <= A + ExtImm
// MEMREAD  | read memory at ALUOut
// MEMWB    | Rd (or PC) <= Data
// MEMWRITE | write WriteData to memory at ALUOut
// EXECUTER | ALUOut <= A op WriteData
// EXECUTEI | ALUOut <= A op ExtImm
// ALUWB    | Rd (or PC) <= ALUOut
// BRANCH   | PC <= PC+8 + imm24<<2
module mc_controller
    import mc_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
`ifdef MEM_WAIT_EN
    input  logic               mem_ready,
`endif
    input  logic [31:0]        Instr,
    input  logic [3:0]         ALUFlags,
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic [1:0]         ResultSrc,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [2:0]         ALUControl,
    output logic [1:0]         ImmSrc,
    output logic [1:0]         RegSrc,
    output logic [STATE_W-1:0] state_o
);
    state_e     state_q, state_d;
    logic [3:0] flags_q;
    logic       cond_q;

    logic [1:0] op;
    logic [5:0] funct;
    logic       rd_pc, mem_rdy, cond_ex;
    logic [2:0] dec_alu_control;
    logic [1:0] dec_flag_w;
    logic       dec_valid;
    logic       ir_w, fetch_pc, reg_w, mem_w, branch, alu_op, pcs;
    logic       unused_instr_bits;

    assign op    = Instr[27:26];
    assign funct = Instr[25:20];
    assign rd_pc = (Instr[15:12] == 4'hF);
    assign unused_instr_bits = ^{Instr[19:16], Instr[11:0]};

`ifdef MEM_WAIT_EN
    assign mem_rdy = mem_ready;
`else
    assign mem_rdy = 1'b1;
`endif

    mc_condcheck u_condcheck (
        .cond_i    (Instr[31:28]),
        .flags_i   (flags_q),
        .cond_ex_o (cond_ex)
    );

    mc_aludec u_aludec (
        .funct_i       (funct[4:0]),
        .alu_control_o (dec_alu_control),
        .flag_w_o      (dec_flag_w),
        .valid_o       (dec_valid)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_FETCH;
        else       state_q <= state_d;
    end

    // Condition latch (DECODE) and flag register (edge ending execute).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cond_q  <= 1'b0;
            flags_q <= 4'b0000;
        end else begin
            if (state_q == ST_DECODE) cond_q <= cond_ex;
            if (alu_op & cond_q & dec_flag_w[1]) flags_q[3:2] <= ALUFlags[3:2];
            if (alu_op & cond_q & dec_flag_w[0]) flags_q[1:0] <= ALUFlags[1:0];
        end
    end

    // Next state and raw Moore outputs.
    always_comb begin
        state_d   = state_q;
        AdrSrc    = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = 1'b0;
        ALUSrcB   = SRCB_WD;
        ir_w      = 1'b0;
        fetch_pc  = 1'b0;
        reg_w     = 1'b0;
        mem_w     = 1'b0;
        branch    = 1'b0;
        alu_op    = 1'b0;
        unique case (state_q)
            ST_FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                ir_w      = mem_rdy;
                fetch_pc  = mem_rdy;
                if (mem_rdy) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                unique case (op)
                    OP_MEM:  state_d = ST_MEMADR;
                    OP_DP:   state_d = funct[5] ? ST_EXECUTEI : ST_EXECUTER;
                    OP_B:    state_d = ST_BRANCH;
                    default: state_d = ST_FETCH;
                endcase
            end
            ST_MEMADR: begin
                ALUSrcB = SRCB_IMM;
                state_d = funct[0] ? ST_MEMREAD : ST_MEMWRITE;
            end
            ST_MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_rdy) state_d = ST_MEMWB;
            end
            ST_MEMWB: begin
                ResultSrc = RES_DATA;
                reg_w     = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_MEMWRITE: begin
                AdrSrc = 1'b1;
                mem_w  = 1'b1;
                if (mem_rdy) state_d = ST_FETCH;
            end
            ST_EXECUTER: begin
                alu_op  = 1'b1;
                state_d = ST_ALUWB;
            end
            ST_EXECUTEI: begin
                ALUSrcB = SRCB_IMM;
                alu_op  = 1'b1;
                state_d = ST_ALUWB;
            end
            ST_ALUWB: begin
                reg_w   = dec_valid;
                state_d = ST_FETCH;
            end
            ST_BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURESULT;
                branch    = 1'b1;
                state_d   = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // Strobe gating: condition, PC-destination redirect, and reset override.
    assign ALUControl = alu_op ? dec_alu_control : ALU_ADD;
    assign pcs        = branch | (reg_w & rd_pc);
    assign PCWrite    = ~reset & (fetch_pc | (pcs & cond_q));
    assign IRWrite    = ~reset & ir_w;
    assign RegWrite   = ~reset & reg_w & cond_q & ~rd_pc;
    assign MemWrite   = ~reset & mem_w & cond_q;

    assign ImmSrc  = op;
    assign RegSrc  = {(op == OP_MEM) & ~funct[0], (op == OP_B)};
    assign state_o = STATE_W'(state_q);

endmodule

// File: tb/tb_mc_controller.sv
// Directed scoreboard bench for mc_controller; MEM_WAIT_EN adds the stall test.
module tb_mc_controller;
    import mc_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
    logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc;
    logic [2:0]  ALUControl;
    logic [3:0]  state_o;
`ifdef MEM_WAIT_EN
    logic        mem_ready = 1'b1;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mc_controller #(.STATE_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
`ifdef MEM_WAIT_EN
        .mem_ready  (mem_ready),
`endif
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .state_o    (state_o)
    );

    // strobes = {PCWrite, IRWrite, MemWrite, RegWrite}
    // sel     = {AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUControl}
    localparam logic [3:0] S_NONE = 4'b0000, S_FETCH = 4'b1100, S_RW = 4'b0001,
                           S_MW = 4'b0010, S_PC = 4'b1000;
    localparam logic [8:0] SEL_FD  = 9'b0_10_1_10_000;
    localparam logic [8:0] SEL_MA  = 9'b0_00_0_01_000;
    localparam logic [8:0] SEL_MEM = 9'b1_00_0_00_000;
    localparam logic [8:0] SEL_MWB = 9'b0_01_0_00_000;
    localparam logic [8:0] SEL_WB  = 9'b0_00_0_00_000;
    localparam logic [8:0] SEL_BR  = 9'b0_10_0_01_000;

    typedef struct {
        string      tag;
        state_e     st;
        logic [3:0] stb;
        logic [8:0] sel;
    } exp_t;

    exp_t sbq[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input state_e st, input logic [3:0] stb,
                        input logic [8:0] sel);
        exp_t e;
        e.tag = tag; e.st = st; e.stb = stb; e.sel = sel;
        sbq.push_back(e);
    endtask

    // Pop one expectation per cycle and compare mid-cycle.
    task automatic drain();
        while (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            #1;
            check({e.tag, ".state"}, 32'(state_o), 32'(e.st));
            check({e.tag, ".strobes"}, {28'd0, PCWrite, IRWrite, MemWrite, RegWrite}, 32'(e.stb));
            check({e.tag, ".sel"}, {23'd0, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUControl},
                  32'(e.sel));
            @(negedge clk);
        end
    endtask

    // Called at a negedge while in FETCH.
    task automatic load(input string tag, input logic [31:0] ins, input logic [3:0] fl,
                        input logic [1:0] imm_exp, input logic [1:0] rs_exp);
        Instr    = ins;
        ALUFlags = fl;
        #1;
        check({tag, ".ImmSrc"}, 32'(ImmSrc), 32'(imm_exp));
        check({tag, ".RegSrc"}, 32'(RegSrc), 32'(rs_exp));
    endtask

    task automatic dp(input string tag, input logic [31:0] ins, input logic [3:0] fl,
                      input logic imm, input logic [2:0] aluc, input logic [3:0] wb_stb);
        load(tag, ins, fl, 2'b00, 2'b00);
        push({tag, ".F"}, ST_FETCH, S_FETCH, SEL_FD);
        push({tag, ".D"}, ST_DECODE, S_NONE, SEL_FD);
        if (imm) push({tag, ".EI"}, ST_EXECUTEI, S_NONE, {6'b0_00_0_01, aluc});
        else     push({tag, ".ER"}, ST_EXECUTER, S_NONE, {6'b0_00_0_00, aluc});
        push({tag, ".WB"}, ST_ALUWB, wb_stb, SEL_WB);
        drain();
    endtask

    task automatic beq(input string tag, input logic [3:0] br_stb);
        load(tag, 32'h0A000002, 4'b0000, 2'b10, 2'b01);
        push({tag, ".F"}, ST_FETCH, S_FETCH, SEL_FD);
        push({tag, ".D"}, ST_DECODE, S_NONE, SEL_FD);
        push({tag, ".B"}, ST_BRANCH, br_stb, SEL_BR);
        drain();
    endtask

    initial begin
        reset    = 1'b1;
        Instr    = 32'h0;
        ALUFlags = 4'b0;
        @(negedge clk);
        #1;
        check("rst.state", 32'(state_o), 32'(ST_FETCH));
        check("rst.strobes", {28'd0, PCWrite, IRWrite, MemWrite, RegWrite}, 32'h0);
        check("rst.flags", 32'(dut.flags_q), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        dp("add_imm", 32'hE2802005, 4'b1111, 1'b1, ALU_ADD, S_RW);
        check("add_imm.flags", 32'(dut.flags_q), 32'h0);

        dp("subs", 32'hE0521003, 4'b0100, 1'b0, ALU_SUB, S_RW);
        check("subs.flags", 32'(dut.flags_q), 32'h4);
        beq("beq_taken", S_PC);

        dp("adds", 32'hE0921003, 4'b0000, 1'b0, ALU_ADD, S_RW);
        check("adds.flags", 32'(dut.flags_q), 32'h0);
        beq("beq_not", S_NONE);

        load("ldr", 32'hE5902000, 4'b0000, 2'b01, 2'b00);
        push("ldr.F", ST_FETCH, S_FETCH, SEL_FD);
        push("ldr.D", ST_DECODE, S_NONE, SEL_FD);
        push("ldr.MA", ST_MEMADR, S_NONE, SEL_MA);
        push("ldr.MR", ST_MEMREAD, S_NONE, SEL_MEM);
        push("ldr.MWB", ST_MEMWB, S_RW, SEL_MWB);
        drain();

        load("str", 32'hE5802000, 4'b0000, 2'b01, 2'b10);
        push("str.F", ST_FETCH, S_FETCH, SEL_FD);
        push("str.D", ST_DECODE, S_NONE, SEL_FD);
        push("str.MA", ST_MEMADR, S_NONE, SEL_MA);
        push("str.MW", ST_MEMWRITE, S_MW, SEL_MEM);
        drain();

        dp("orrs", 32'hE1921003, 4'b1011, 1'b0, ALU_ORR, S_RW);
        check("orrs.flags", 32'(dut.flags_q), 32'h8);

        dp("mov_pc", 32'hE1A0F001, 4'b0110, 1'b0, ALU_MOV, S_PC);
        check("mov_pc.flags", 32'(dut.flags_q), 32'h8);

        dp("eors_nop", 32'hE0321003, 4'b0110, 1'b0, ALU_ADD, S_NONE);
        check("eors_nop.flags", 32'(dut.flags_q), 32'h8);

        // Reset arriving in the middle of a store.
        load("str_rst", 32'hE5802000, 4'b0000, 2'b01, 2'b10);
        push("str_rst.F", ST_FETCH, S_FETCH, SEL_FD);
        push("str_rst.D", ST_DECODE, S_NONE, SEL_FD);
        push("str_rst.MA", ST_MEMADR, S_NONE, SEL_MA);
        drain();
        #1;
        check("str_rst.pre_state", 32'(state_o), 32'(ST_MEMWRITE));
        check("str_rst.pre_mw", 32'(MemWrite), 32'h1);
        reset = 1'b1;
        #1;
        check("str_rst.mw", 32'(MemWrite), 32'h0);
        check("str_rst.state", 32'(state_o), 32'(ST_FETCH));
        check("str_rst.strobes", {28'd0, PCWrite, IRWrite, MemWrite, RegWrite}, 32'h0);
        check("str_rst.flags", 32'(dut.flags_q), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        dp("post_rst", 32'hE2802005, 4'b0000, 1'b1, ALU_ADD, S_RW);
        #1;
        check("end.state", 32'(state_o), 32'(ST_FETCH));

`ifdef MEM_WAIT_EN
        @(negedge clk);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("wait.state", 32'(state_o), 32'(ST_FETCH));
            check("wait.irpc", {30'd0, IRWrite, PCWrite}, 32'h0);
            @(negedge clk);
        end
        mem_ready = 1'b1;
        #1;
        check("wait.pulse", {30'd0, IRWrite, PCWrite}, 32'h3);
        @(negedge clk);
        #1;
        check("wait.decode", 32'(state_o), 32'(ST_DECODE));
        check("wait.after", {30'd0, IRWrite, PCWrite}, 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
